// File: rtl/reg_ram_pkg.sv
// Shared state encodings for the reg_ram read and write handshake FSMs.
package reg_ram_pkg;

    typedef enum logic {
        W_IDLE,
        W_ACK
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_ACK
    } r_state_t;

endpackage

// File: rtl/reg_ram_core.sv
// Simple dual-port synchronous RAM: one write port, one registered read-first read port.
module reg_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // Contents are deliberately not reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/reg_ram.sv
// Register memory terminating the r_mem / w_mem buses with four-phase handshakes.
// Optional REG_RAM_BYPASS_EN: a same-edge read of the address being written returns the new data.
module reg_ram
    import reg_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_DEPTH      = 256,
    localparam int LB_RAM_DEPTH  = $clog2(RAM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [LB_RAM_DEPTH-1:0] w_mem_addr,
    input  logic [DATA_WIDTH-1:0]   w_mem_data,
    input  logic                    w_mem_valid,
    output logic                    w_mem_ready,
    input  logic [LB_RAM_DEPTH-1:0] r_mem_addr,
    input  logic                    r_mem_valid,
    output logic [DATA_WIDTH-1:0]   r_mem_data,
    output logic                    r_mem_ready
);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic w_we, ram_we;
    logic r_re, r_cap;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] fetch_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next      = w_state;
        w_we        = 1'b0;
        w_mem_ready = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (w_mem_valid) begin
                    w_we   = 1'b1;
                    w_next = W_ACK;
                end
            end
            W_ACK: begin
                w_mem_ready = 1'b1;
                if (!w_mem_valid) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // The RAM has no reset, so block commits while reset is held.
    assign ram_we = w_we & rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next      = r_state;
        r_re        = 1'b0;
        r_cap       = 1'b0;
        r_mem_ready = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (r_mem_valid) begin
                    r_re   = 1'b1;
                    r_next = R_FETCH;
                end
            end
            R_FETCH: begin
                r_cap  = 1'b1;
                r_next = R_ACK;
            end
            R_ACK: begin
                r_mem_ready = 1'b1;
                if (!r_mem_valid) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    reg_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (ram_we),
        .waddr (w_mem_addr),
        .wdata (w_mem_data),
        .re    (r_re),
        .raddr (r_mem_addr),
        .rdata (ram_rdata)
    );

`ifdef REG_RAM_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;

    // Collision is resolved one cycle later, alongside the RAM's registered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else if (r_re) begin
            byp_hit  <= ram_we && (w_mem_addr == r_mem_addr);
            byp_data <= w_mem_data;
        end
    end

    assign fetch_data = byp_hit ? byp_data : ram_rdata;
`else
    assign fetch_data = ram_rdata;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_data <= '0;
        end else if (r_cap) begin
            r_mem_data <= fetch_data;
        end
    end

endmodule

// File: tb/tb_reg_ram.sv
// Scoreboard bench for reg_ram: read expectations are queued, a monitor checks each read ack.
module tb_reg_ram;

    localparam int DW = 32;
    localparam int AW = 8;

`ifdef REG_RAM_BYPASS_EN
    localparam logic [DW-1:0] COLL_EXP = 32'h55;
`else
    localparam logic [DW-1:0] COLL_EXP = 32'h10;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] w_mem_addr = '0;
    logic [DW-1:0] w_mem_data = '0;
    logic          w_mem_valid = 1'b0;
    logic          w_mem_ready;
    logic [AW-1:0] r_mem_addr = '0;
    logic          r_mem_valid = 1'b0;
    logic [DW-1:0] r_mem_data;
    logic          r_mem_ready;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic prev_rr = 1'b0;

    always #5 clk = ~clk;

    reg_ram #(
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (256)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .w_mem_addr  (w_mem_addr),
        .w_mem_data  (w_mem_data),
        .w_mem_valid (w_mem_valid),
        .w_mem_ready (w_mem_ready),
        .r_mem_addr  (r_mem_addr),
        .r_mem_valid (r_mem_valid),
        .r_mem_data  (r_mem_data),
        .r_mem_ready (r_mem_ready)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising read ack consumes one queued expectation.
    always @(negedge clk) begin
        if (r_mem_ready && !prev_rr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read_ack: got data 0x%0h with no expectation queued", r_mem_data);
            end else begin
                chk("read_data", r_mem_data, exp_q.pop_front());
            end
        end
        prev_rr = r_mem_ready;
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
        int n;
        @(negedge clk);
        w_mem_addr  = a;
        w_mem_data  = d;
        w_mem_valid = 1'b1;
        n = 0;
        while (!w_mem_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_wlat"}, n, 1);
        w_mem_valid = 1'b0;
        @(negedge clk);
        chk({name, "_wdrop"}, w_mem_ready, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input string name);
        int n;
        exp_q.push_back(e);
        @(negedge clk);
        r_mem_addr  = a;
        r_mem_valid = 1'b1;
        n = 0;
        while (!r_mem_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rlat"}, n, 2);
        r_mem_valid = 1'b0;
        @(negedge clk);
        chk({name, "_rdrop"}, r_mem_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_w_ready", w_mem_ready, 0);
        chk("rst_r_ready", r_mem_ready, 0);
        chk("rst_r_data", r_mem_data, 0);
        rstn = 1'b1;

        // Write then read
        do_write(8'h0F, 32'h77, "wr0f");
        do_read(8'h0F, 32'h77, "rd0f");

        // Concurrent transactions to different addresses
        do_write(8'h08, 32'h79, "wr08");
        fork
            do_write(8'h04, 32'h80, "conc_w");
            do_read(8'h08, 32'h79, "conc_r");
        join
        do_read(8'h04, 32'h80, "rd04");

        // Same-edge collision
        do_write(8'h20, 32'h10, "wr20");
        fork
            do_write(8'h20, 32'h55, "coll_w");
            do_read(8'h20, COLL_EXP, "coll_r");
        join
        do_read(8'h20, 32'h55, "rd20");

        // Held valid: only the first edge writes
        @(negedge clk);
        w_mem_addr  = 8'h01;
        w_mem_data  = 32'hA;
        w_mem_valid = 1'b1;
        @(negedge clk);
        chk("held_ack", w_mem_ready, 1);
        w_mem_data = 32'hB;
        repeat (4) @(negedge clk);
        chk("held_still_ack", w_mem_ready, 1);
        w_mem_valid = 1'b0;
        @(negedge clk);
        chk("held_drop", w_mem_ready, 0);
        do_read(8'h01, 32'hA, "held_rd");

        // Early drop of read valid
        do_write(8'hFF, 32'h3C, "wrff");
        exp_q.push_back(32'h3C);
        @(negedge clk);
        r_mem_addr  = 8'hFF;
        r_mem_valid = 1'b1;
        @(negedge clk);
        r_mem_valid = 1'b0;
        chk("early_c1", r_mem_ready, 0);
        @(negedge clk);
        chk("early_c2", r_mem_ready, 1);
        @(negedge clk);
        chk("early_c3", r_mem_ready, 0);
        @(negedge clk);
        chk("early_c4", r_mem_ready, 0);
        do_read(8'hFF, 32'h3C, "after_early");

        // Reset during R_FETCH discards the read
        do_write(8'h30, 32'h99, "wr30");
        do_read(8'h30, 32'h99, "rd30");
        @(negedge clk);
        r_mem_addr  = 8'h0F;
        r_mem_valid = 1'b1;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_ready", r_mem_ready, 0);
        chk("midrst_data", r_mem_data, 0);
        r_mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        do_read(8'h0F, 32'h77, "post_rst");

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
